// File: rtl/refresh_controller.sv
// Rotating-spare refresh controller: copies one logical bank's physical wrapper into the
// spare each pass, retires the source as the new spare, and steers user enables.
module refresh_controller #(
    parameter int NUM_LOG    = 4,
    parameter int NUM_BANKS  = NUM_LOG + 1,
    parameter int REF_PERIOD = 1024,
    parameter int TIMEOUT    = 256,
    parameter int BW         = $clog2(NUM_BANKS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       u_we,
    input  logic                       u_re,
    input  logic [$clog2(NUM_LOG)-1:0] u_bank,
    input  logic                       ref_force,
    input  logic [NUM_BANKS-1:0]       ref_done,
    output logic [NUM_BANKS-1:0]       start_sr,
    output logic [NUM_BANKS-1:0]       ref_en_src,
    output logic [NUM_BANKS-1:0]       ref_en_dst,
    output logic [NUM_BANKS-1:0]       we_sel,
    output logic [NUM_BANKS-1:0]       re_sel,
    output logic [BW-1:0]              rd_bank,
    output logic                       busy,
    output logic                       ref_err
);

    localparam int LW = $clog2(NUM_LOG);
    localparam int PW = $clog2(REF_PERIOD + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, START, REFRESH, SWAP} state_t;

    state_t        state;
    state_t        state_next;
    logic [BW-1:0] map [NUM_LOG];
    logic [BW-1:0] spare;
    logic [BW-1:0] src;
    logic [BW-1:0] dst;
    logic [LW-1:0] victim;
    logic [PW-1:0] period_cnt;
    logic [TW-1:0] to_cnt;

    logic          period_hit;
    logic          timeout_hit;
    logic          src_done;
    logic          pass_active;
    logic          steer_hit;
    logic [BW-1:0] rd_target;

    assign period_hit  = (period_cnt == PW'(REF_PERIOD - 1));
    assign timeout_hit = (to_cnt == TW'(TIMEOUT - 1));
    assign src_done    = ref_done[src];
    assign pass_active = (state != IDLE);
    // The victim's data lives in src until SWAP commits, so reads of it stay on src.
    assign steer_hit   = pass_active && (u_bank == victim);
    assign rd_target   = steer_hit ? src : map[u_bank];
    assign busy        = pass_active;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (period_hit || ref_force) state_next = START;
            START:   state_next = REFRESH;
            REFRESH: begin
                if (src_done) begin
                    state_next = SWAP;
                end else if (timeout_hit) begin
                    state_next = IDLE;
                end
            end
            SWAP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // src/dst are captured on the IDLE->START edge; map and spare cannot change in IDLE,
    // so this matches sampling them during START and lets START drive the enables directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_LOG; i++) begin
                map[i] <= BW'(i);
            end
            spare      <= BW'(NUM_LOG);
            src        <= '0;
            dst        <= '0;
            victim     <= '0;
            period_cnt <= '0;
            to_cnt     <= '0;
            ref_err    <= 1'b0;
            rd_bank    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (state_next == START) begin
                        period_cnt <= '0;
                        src        <= map[victim];
                        dst        <= spare;
                    end else begin
                        period_cnt <= period_cnt + PW'(1);
                    end
                end
                START: to_cnt <= '0;
                REFRESH: begin
                    to_cnt <= to_cnt + TW'(1);
                    if (!src_done && timeout_hit) begin
                        ref_err <= 1'b1;
                    end
                end
                SWAP: begin
                    map[victim] <= dst;
                    spare       <= src;
                    victim      <= (victim == LW'(NUM_LOG - 1)) ? '0 : victim + LW'(1);
                end
                default: ;
            endcase
            if (u_re) begin
                rd_bank <= rd_target;
            end
        end
    end

    // Writes to the victim during a pass go to both copies so the spare stays coherent.
    always_comb begin
        start_sr   = '0;
        ref_en_src = '0;
        ref_en_dst = '0;
        we_sel     = '0;
        re_sel     = '0;
        if (state == START) begin
            start_sr[src] = 1'b1;
        end
        if (pass_active) begin
            ref_en_src[src] = 1'b1;
            ref_en_dst[dst] = 1'b1;
        end
        if (u_we) begin
            if (steer_hit) begin
                we_sel[src] = 1'b1;
                we_sel[dst] = 1'b1;
            end else begin
                we_sel[map[u_bank]] = 1'b1;
            end
        end
        if (u_re) begin
            re_sel[rd_target] = 1'b1;
        end
    end

endmodule
